softmax_row_packer: RTL and testbench
=====================================

Name: softmax_row_packer

Overview:
- Transmitter side of the softmax row interface.
- Accepts int8 attention scores serially, one element per cycle, from the QK^T matmul drain.
- Packs each score row into a 256-bit lane vector, padding unused lanes, and drives it to softmax over a valid/ready handshake.
- A small row FIFO absorbs softmax backpressure so the matmul drain is not stalled per row.

Parameters:
- LANES, 32, lanes per row vector.
- DW, 8, bits per lane (signed int8 score).
- DEPTH, 2, row FIFO entries (power of 2, at least 2).
- PAD_VAL, 8'h80, value written to lanes at or above the row length (-128, so exp is approximately 0 in softmax).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- seq_len  in  6  valid elements per row, 1..32; 0 or >32 is treated as 32; sampled on the first element of each row.
- elem_valid  in  1  score element valid.
- elem_ready  out  1  packer can accept an element.
- elem_data  in  DW  signed score.
- elem_last  in  1  marks the last element of a row.
- row_abort  in  1  discards the partially packed row.
- out_valid  out  1  row vector valid toward softmax (softmax data_in_valid).
- out_ready  in  1  softmax can accept (softmax data_in_ready).
- out_data  out  LANES*DW  packed row; lane k is at bits [8k+7:8k].
- row_count  out  16  rows delivered (out handshakes), wraps.
- err_short  out  1  sticky: a row closed by elem_last before seq_len elements.
- err_long  out  1  sticky: a row closed by seq_len with elem_last low.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, elem_ready=0 while rst=1.
  - row_count=0, err_short=0, err_long=0.
  - FIFO empty, idx=0, state=IDLE.
  - Effective seq_len register reset value is 32.
- Element accept occurs when elem_valid && elem_ready.
- elem_ready is registered and equals (fifo_count<DEPTH) && !rst. There is no combinational path from out_ready.
- States:
  - IDLE: idx=0. On accept, latch len_q = clamp(seq_len), write lane 0, go to FILL. If len_q=1 or elem_last, close the row immediately.
  - FILL: each accept writes lane idx and increments idx. The row closes on the accept where idx==len_q-1 or elem_last=1, whichever is first. On close, return to IDLE.
- Close action:
  - Lanes >= idx+1 are set to PAD_VAL.
  - The full vector (including the closing element, merged combinationally) is pushed into the FIFO at that edge.
  - The packing register is cleared to PAD_VAL.
- Close flags:
  - If closed by elem_last with idx+1<len_q, set err_short.
  - If closed by len_q with elem_last=0, set err_long. The next element starts a new row.
- Output side:
  - out_valid = FIFO non-empty; out_data = FIFO head, registered.
  - Pop on out_valid && out_ready.
  - out_data and out_valid must stay stable while out_valid && !out_ready.
- Latency: with the FIFO empty, a closing accept at edge N gives out_valid=1 after edge N, in the cycle following the close.
- Simultaneous push and pop with the FIFO full cannot occur, because elem_ready=0 when full.
  - Push and pop in the same cycle with count<DEPTH leaves the count unchanged.
- Full FIFO: elem_ready drops the cycle after count reaches DEPTH. It rises the cycle after a pop.
- row_abort:
  - Highest priority over an accept in the same cycle; that element is dropped.
  - Clears idx, sets the packing register to PAD_VAL, goes to IDLE.
  - The FIFO and its contents are untouched.
- row_count increments on each pop and wraps 0xFFFF to 0.
- Reset asserted mid-row or mid-stall drops all buffered rows immediately.

Decomposition:
- Shared package softmax_pkg:
  - constants LANES=32, DW=8, ROW_W=256, PAD_VAL.
  - typedef row_t (logic [ROW_W-1:0]).
  - enum pack_state_t {IDLE, FILL}.
  - function clamp_len.
- One natural sub-module: row_fifo, a DEPTH x ROW_W synchronous FIFO with registered head, count output, and async active-high rst.
- Packer FSM and counters stay in the top module.

Test Plan:
- seq_len=32, elements 0..31 with elem_last on the 32nd, out_ready=1 -> one row; out_data[8k+7:8k]=k; out_valid one cycle after the last accept; row_count=1; no errors.
- seq_len=28, 28 elements of 8'h05 with last on the 28th -> lanes 0..27 = 05, lanes 28..31 = 80, err_short=0.
- seq_len=32, elem_last on the 10th element -> lanes 10..31 = 80; err_short=1 and stays set after a further clean row.
- out_ready=0, three 4-element rows (seq_len=4) streamed -> two rows buffered; elem_ready=0 after the second close; out_data held stable. Raising out_ready delivers rows in order, elem_ready returns, the third row follows, and row_count=3.
- row_abort after 5 elements, then a clean 4-element row -> only the clean row appears; no lanes from the aborted row leak into it.
- rst asserted with 2 rows buffered and a partial row in progress -> out_valid=0 immediately; after release, row_count=0 and the first new row packs from lane 0.

Source files
------------

// File: rtl/softmax_pkg.sv
// Shared types and constants for the softmax row interface: lane geometry, the pad value
// that softmax turns into exp()~0, and the row-length clamp.
package softmax_pkg;

    localparam int LANES = 32;
    localparam int DW    = 8;
    localparam int ROW_W = LANES * DW;
    localparam logic [DW-1:0] PAD_VAL = 8'h80;

    typedef logic [ROW_W-1:0] row_t;

    typedef enum logic {
        IDLE,
        FILL
    } pack_state_t;

    // A length of 0 or anything beyond the lane count means "use every lane".
    function automatic logic [5:0] clamp_len(input logic [5:0] len);
        return ((len == 6'd0) || (len > 6'd32)) ? 6'd32 : len;
    endfunction

    function automatic row_t pad_row();
        return {LANES{PAD_VAL}};
    endfunction

endpackage

// File: rtl/softmax_row_packer_row_fifo.sv
// DEPTH x W row FIFO with a registered head. A push into an empty FIFO is visible on the next cycle.
// The caller must never push when count_o == DEPTH; pop is ignored when empty.
module row_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [W-1:0]               push_data_i,
    input  logic                       pop_i,
    output logic                       valid_o,
    output logic [W-1:0]               head_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  head_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
    logic [CW-1:0] count_q;
    logic          do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign rd_nxt  = rd_ptr_q + 1'b1;
    assign valid_o = (count_q != '0);
    assign head_o  = head_q;
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_nxt;
            end
            if (push_i && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !push_i) begin
                count_q <= count_q - 1'b1;
            end
            // The head tracks the oldest entry; a push only reaches it when nothing older remains.
            if (do_pop) begin
                if (count_q > CW'(1)) begin
                    head_q <= mem_q[rd_nxt];
                end else if (push_i) begin
                    head_q <= push_data_i;
                end
            end else if (push_i && (count_q == '0)) begin
                head_q <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/softmax_row_packer.sv
// Packs serial int8 scores into 32-lane rows; a closing accept shows on out_valid the next cycle.
// Row FIFO absorbs softmax stalls; elem_ready is registered and drops only when the FIFO is full.
module softmax_row_packer
    import softmax_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       seq_len,
    input  logic             elem_valid,
    output logic             elem_ready,
    input  logic [DW-1:0]    elem_data,
    input  logic             elem_last,
    input  logic             row_abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROW_W-1:0] out_data,
    output logic [15:0]      row_count,
    output logic             err_short,
    output logic             err_long
);
    localparam int CW = $clog2(DEPTH) + 1;

    pack_state_t   state_q, state_d;
    logic [4:0]    idx_q, idx_d, cur_idx;
    logic [5:0]    len_q, len_d, cur_len;
    row_t          pack_q, pack_d, merged;
    logic          ready_q, ready_d;
    logic          short_q, short_d, long_q, long_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          accept, at_len, close_row, pop;
    logic [CW-1:0] fifo_count, count_nxt;

    assign accept     = elem_valid && ready_q && !row_abort;
    assign pop        = out_valid && out_ready;
    assign elem_ready = ready_q;
    assign row_count  = cnt_q;
    assign err_short  = short_q;
    assign err_long   = long_q;

    // In IDLE the row length comes straight from the port so the first element can close a 1-lane row.
    always_comb begin
        cur_idx   = (state_q == IDLE) ? 5'd0 : idx_q;
        cur_len   = (state_q == IDLE) ? clamp_len(seq_len) : len_q;
        at_len    = ({1'b0, cur_idx} == (cur_len - 6'd1));
        close_row = accept && (elem_last || at_len);
        merged    = pack_q;
        for (int k = 0; k < LANES; k++) begin
            if (5'(k) == cur_idx) begin
                merged[k*DW +: DW] = elem_data;
            end else if (5'(k) > cur_idx) begin
                merged[k*DW +: DW] = PAD_VAL;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        pack_d  = pack_q;
        short_d = short_q;
        long_d  = long_q;
        cnt_d   = cnt_q + (pop ? 16'd1 : 16'd0);
        if (row_abort) begin
            state_d = IDLE;
            idx_d   = 5'd0;
            pack_d  = pad_row();
        end else if (accept) begin
            if (state_q == IDLE) begin
                len_d = cur_len;
            end
            if (close_row) begin
                state_d = IDLE;
                idx_d   = 5'd0;
                pack_d  = pad_row();
                if (elem_last && !at_len) begin
                    short_d = 1'b1;
                end
                if (!elem_last) begin
                    long_d = 1'b1;
                end
            end else begin
                state_d = FILL;
                idx_d   = cur_idx + 5'd1;
                pack_d  = merged;
            end
        end
    end

    always_comb begin
        count_nxt = fifo_count;
        if (close_row && !pop) begin
            count_nxt = fifo_count + 1'b1;
        end else if (pop && !close_row) begin
            count_nxt = fifo_count - 1'b1;
        end
        ready_d = (count_nxt < CW'(DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 5'd0;
            len_q   <= 6'd32;
            pack_q  <= pad_row();
            ready_q <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            pack_q  <= pack_d;
            ready_q <= ready_d;
            short_q <= short_d;
            long_q  <= long_d;
            cnt_q   <= cnt_d;
        end
    end

    row_fifo #(
        .DEPTH (DEPTH),
        .W     (ROW_W)
    ) u_row_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (close_row),
        .push_data_i (merged),
        .pop_i       (pop),
        .valid_o     (out_valid),
        .head_o      (out_data),
        .count_o     (fifo_count)
    );

endmodule

// File: tb/tb_softmax_row_packer.sv
// Directed bench for softmax_row_packer: hand-built expected rows, popped rows collected at negedge.
module tb_softmax_row_packer;
    import softmax_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       seq_len;
    logic             elem_valid, elem_ready, elem_last, row_abort;
    logic [DW-1:0]    elem_data;
    logic             out_valid, out_ready;
    logic [ROW_W-1:0] out_data;
    logic [15:0]      row_count;
    logic             err_short, err_long;

    int   errors = 0;
    int   checks = 0;
    row_t popped_q [$];

    always #5 clk = ~clk;

    softmax_row_packer #(.DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .seq_len    (seq_len),
        .elem_valid (elem_valid),
        .elem_ready (elem_ready),
        .elem_data  (elem_data),
        .elem_last  (elem_last),
        .row_abort  (row_abort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .row_count  (row_count),
        .err_short  (err_short),
        .err_long   (err_long)
    );

    // Inputs only move at posedge+1, so negedge values are what the next edge sees.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            popped_q.push_back(out_data);
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic row_t mk_row(input logic [7:0] base, input logic [7:0] step, input int n);
        row_t r;
        r = {LANES{PAD_VAL}};
        for (int k = 0; k < n; k++) begin
            r[k*8 +: 8] = base + 8'(k) * step;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last, input logic [5:0] len);
        int t;
        t          = 0;
        seq_len    = len;
        elem_data  = d;
        elem_last  = last;
        elem_valid = 1'b1;
        while (!elem_ready && t < 100) begin
            tick();
            t++;
        end
        chk("elem_ready_wait", elem_ready, 1'b1);
        tick();
        elem_valid = 1'b0;
        elem_last  = 1'b0;
    endtask

    task automatic send_row(input logic [7:0] base, input logic [7:0] step, input int n,
                            input logic [5:0] len, input logic last_on_n);
        for (int i = 0; i < n; i++) begin
            send(base + 8'(i) * step, last_on_n && (i == n - 1), len);
        end
    endtask

    task automatic expect_row(input string tag, input row_t exp);
        int t;
        t = 0;
        while (popped_q.size() == 0 && t < 50) begin
            tick();
            t++;
        end
        chk({tag, "_seen"}, popped_q.size() != 0, 1'b1);
        if (popped_q.size() != 0) begin
            chk(tag, popped_q.pop_front(), exp);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        elem_valid = 1'b0;
        elem_last  = 1'b0;
        row_abort  = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        popped_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        seq_len    = 6'd32;
        elem_valid = 1'b0;
        elem_data  = 8'h00;
        elem_last  = 1'b0;
        row_abort  = 1'b0;
        out_ready  = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_elem_ready", elem_ready, 1'b0);
        chk("rst_row_count", row_count, 16'd0);
        chk("rst_err_short", err_short, 1'b0);
        chk("rst_err_long", err_long, 1'b0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("rel_elem_ready", elem_ready, 1'b1);

        // Full 32-lane ramp
        out_ready = 1'b1;
        send_row(8'h00, 8'h01, 32, 6'd32, 1'b1);
        chk("t1_latency", out_valid, 1'b1);
        expect_row("t1_row", mk_row(8'h00, 8'h01, 32));
        chk("t1_row_count", row_count, 16'd1);
        chk("t1_err_short", err_short, 1'b0);
        chk("t1_err_long", err_long, 1'b0);

        // 28-element row, tail padded
        send_row(8'h05, 8'h00, 28, 6'd28, 1'b1);
        expect_row("t2_row", mk_row(8'h05, 8'h00, 28));
        chk("t2_err_short", err_short, 1'b0);
        chk("t2_row_count", row_count, 16'd2);

        // Early elem_last, then sticky flag survives a clean row
        send_row(8'h10, 8'h01, 10, 6'd32, 1'b1);
        expect_row("t3_short_row", mk_row(8'h10, 8'h01, 10));
        chk("t3_err_short", err_short, 1'b1);
        send_row(8'h01, 8'h01, 4, 6'd4, 1'b1);
        expect_row("t3_clean_row", mk_row(8'h01, 8'h01, 4));
        chk("t3_err_short_sticky", err_short, 1'b1);
        chk("t3_err_long", err_long, 1'b0);

        // Row closed by length with no elem_last, next element starts a new row
        send_row(8'h20, 8'h01, 3, 6'd3, 1'b0);
        expect_row("t3_long_row", mk_row(8'h20, 8'h01, 3));
        chk("t3_err_long", err_long, 1'b1);
        send_row(8'h30, 8'h01, 2, 6'd2, 1'b1);
        expect_row("t3_after_long", mk_row(8'h30, 8'h01, 2));
        chk("t3_row_count", row_count, 16'd6);

        // Backpressure: two rows fill the FIFO
        do_reset();
        out_ready = 1'b0;
        send_row(8'hA0, 8'h01, 4, 6'd4, 1'b1);
        send_row(8'hB0, 8'h01, 4, 6'd4, 1'b1);
        chk("t4_ready_low", elem_ready, 1'b0);
        chk("t4_valid", out_valid, 1'b1);
        chk("t4_head", out_data, mk_row(8'hA0, 8'h01, 4));
        repeat (4) tick();
        chk("t4_head_stable", out_data, mk_row(8'hA0, 8'h01, 4));
        chk("t4_valid_stable", out_valid, 1'b1);
        chk("t4_ready_still_low", elem_ready, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("t4_ready_back", elem_ready, 1'b1);
        chk("t4_head_b", out_data, mk_row(8'hB0, 8'h01, 4));
        send_row(8'hC0, 8'h01, 4, 6'd4, 1'b1);
        expect_row("t4_row_a", mk_row(8'hA0, 8'h01, 4));
        expect_row("t4_row_b", mk_row(8'hB0, 8'h01, 4));
        expect_row("t4_row_c", mk_row(8'hC0, 8'h01, 4));
        tick();
        chk("t4_row_count", row_count, 16'd3);

        // Abort a partial row; the aborting cycle's element is dropped
        send_row(8'h55, 8'h00, 5, 6'd8, 1'b0);
        row_abort  = 1'b1;
        elem_valid = 1'b1;
        elem_data  = 8'h77;
        tick();
        row_abort  = 1'b0;
        elem_valid = 1'b0;
        send_row(8'h01, 8'h01, 4, 6'd4, 1'b1);
        expect_row("t5_clean_row", mk_row(8'h01, 8'h01, 4));
        repeat (3) tick();
        chk("t5_no_extra_rows", popped_q.size(), 0);
        chk("t5_row_count", row_count, 16'd4);
        chk("t5_err_short", err_short, 1'b0);

        // Reset with a buffered row and a row half packed
        out_ready = 1'b0;
        send_row(8'hD0, 8'h01, 4, 6'd4, 1'b1);
        send_row(8'hE0, 8'h01, 2, 6'd4, 1'b0);
        rst        = 1'b1;
        elem_valid = 1'b0;
        #1;
        chk("t6_valid_drop", out_valid, 1'b0);
        chk("t6_ready_drop", elem_ready, 1'b0);
        chk("t6_data_clear", out_data, '0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        popped_q.delete();
        chk("t6_row_count", row_count, 16'd0);
        chk("t6_valid_empty", out_valid, 1'b0);
        out_ready = 1'b1;
        send_row(8'h40, 8'h01, 4, 6'd4, 1'b1);
        expect_row("t6_new_row", mk_row(8'h40, 8'h01, 4));
        chk("t6_row_count_after", row_count, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
